data_bus_bridge: RTL and testbench



---
 rtl/data_bus_bridge_pkg.sv | 40 ++++
 rtl/data_bus_bridge_addr_decode.sv | 33 +++
 rtl/data_bus_bridge.sv | 166 ++++++++++++++++
 tb/tb_data_bus_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_bridge_pkg
// Description : Shared types and constants for the CPU data bus bridge:
//               word/bit typedefs, memory map constants, one-hot region
//               indices and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package data_bus_bridge_pkg;

    typedef logic [31:0] Word_t;
    typedef logic        Bit_t;

    // Memory map. Ranges are [BASE, LIMIT).
    localparam Word_t c_SRAM_BASE      = 32'h8040_0000;
    localparam Word_t c_SRAM_LIMIT     = 32'h8080_0000;
    localparam Word_t c_UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam Word_t c_UART_STAT_ADDR = 32'hBFD0_03FC;
    localparam Word_t c_VGA_BASE       = 32'hBA00_0000;
    localparam Word_t c_VGA_LIMIT      = 32'hBA07_5300;
    localparam Word_t c_VGA_ADDR_MASK  = 32'h000F_FFFF;

    // One-hot region vector bit positions.
    localparam int c_REGION_W     = 5;
    localparam int c_RGN_SRAM     = 0;
    localparam int c_RGN_UART_DAT = 1;
    localparam int c_RGN_UART_STA = 2;
    localparam int c_RGN_VGA      = 3;
    localparam int c_RGN_UNMAPPED = 4;

    typedef logic [c_REGION_W-1:0] Region_t;

    // Bridge FSM state encodings.
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_SRAM_ACC = 2'd1;
    localparam logic [1:0] c_ST_UART_ACC = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

endpackage : data_bus_bridge_pkg
`default_nettype wire

// File: rtl/data_bus_bridge_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_addr_decode
// Description : Combinational address decoder. Maps a CPU virtual data
//               address to exactly one region bit.
// Ports       : cpu_addr (in, 32)  - address to decode
//               region   (out, 5)  - one-hot region (see package indices)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_decode
    import data_bus_bridge_pkg::*;
(
    input  logic [31:0] cpu_addr,
    output Region_t     region
);

    always_comb begin
        region = '0;
        if (cpu_addr >= c_SRAM_BASE && cpu_addr < c_SRAM_LIMIT) begin
            region[c_RGN_SRAM] = 1'b1;
        end else if (cpu_addr == c_UART_DATA_ADDR) begin
            region[c_RGN_UART_DAT] = 1'b1;
        end else if (cpu_addr == c_UART_STAT_ADDR) begin
            region[c_RGN_UART_STA] = 1'b1;
        end else if (cpu_addr >= c_VGA_BASE && cpu_addr < c_VGA_LIMIT) begin
            region[c_RGN_VGA] = 1'b1;
        end else begin
            region[c_RGN_UNMAPPED] = 1'b1;
        end
    end

endmodule : bus_addr_decode
`default_nettype wire

// File: rtl/data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_bridge
// Description : Bridges the CPU data port to SRAM, UART and VGA. SRAM and
//               UART data accesses stall the CPU for WAIT+1 cycles through a
//               small FSM; UART status, VGA and unmapped accesses complete in
//               the request cycle with no stall.
// Ports       : clk, rst (async, active-high)
//               cpu_*  - CPU request / response
//               sram_* - SRAM op, address, data, mask
//               uart_* - UART ops, data, status bits
//               vga_*  - VGA write port
//               bus_error - sticky unmapped-access flag
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int UART_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_mask,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        sram_read_op,
    output logic        sram_write_op,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_data_write,
    output logic [3:0]  sram_byte_mask,
    input  logic [31:0] sram_data_read,
    output logic        uart_read_op,
    output logic        uart_write_op,
    output logic [31:0] uart_data_write,
    input  logic [31:0] uart_data_read,
    input  logic [1:0]  uart_mode,
    output logic        vga_write_op,
    output logic [31:0] vga_addr,
    output logic [31:0] vga_data_write,
    output logic        bus_error
);

    Region_t     w_region;
    logic        w_req;
    logic        w_rd;
    logic        w_slow_req;
    logic        w_last;
    logic        w_latch;
    logic [1:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_write;
    logic [31:0] r_rdata;
    logic        r_bus_error;

    bus_addr_decode u_decode (
        .cpu_addr (cpu_addr),
        .region   (w_region)
    );

    // Read-and-write together counts as a write.
    assign w_req      = cpu_re | cpu_we;
    assign w_rd       = cpu_re & ~cpu_we;
    assign w_slow_req = w_req & (w_region[c_RGN_SRAM] | w_region[c_RGN_UART_DAT]);

    assign w_last = (r_state == c_ST_SRAM_ACC) ? (r_cnt == 4'(SRAM_WAIT - 1))
                                               : (r_cnt == 4'(UART_WAIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_slow_req) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = w_region[c_RGN_SRAM] ? c_ST_SRAM_ACC : c_ST_UART_ACC;
                end
            end
            c_ST_SRAM_ACC, c_ST_UART_ACC: begin
                if (w_last) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            c_ST_DONE: begin
                // Any request still present is ignored here.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_write     <= 1'b0;
            r_rdata     <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr  <= cpu_addr[21:0];
                r_wdata <= cpu_wdata;
                r_mask  <= cpu_mask;
                r_write <= cpu_we;
            end
            if ((r_state == c_ST_SRAM_ACC || r_state == c_ST_UART_ACC) && w_last) begin
                r_rdata <= (r_state == c_ST_SRAM_ACC) ? sram_data_read : uart_data_read;
            end
            if (r_state == c_ST_IDLE && w_req && w_region[c_RGN_UNMAPPED]) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // Ops decode straight from the state register so an asynchronous reset
    // drops them in the same cycle.
    assign sram_read_op    = (r_state == c_ST_SRAM_ACC) & ~r_write;
    assign sram_write_op   = (r_state == c_ST_SRAM_ACC) &  r_write;
    assign uart_read_op    = (r_state == c_ST_UART_ACC) & ~r_write;
    assign uart_write_op   = (r_state == c_ST_UART_ACC) &  r_write;
    assign sram_addr       = {10'b0, r_addr};
    assign sram_data_write = r_wdata;
    assign sram_byte_mask  = r_mask;
    assign uart_data_write = r_wdata;

    assign vga_write_op    = (r_state == c_ST_IDLE) & cpu_we & w_region[c_RGN_VGA];
    assign vga_addr        = cpu_addr & c_VGA_ADDR_MASK;
    assign vga_data_write  = cpu_wdata;

    assign cpu_stall = (r_state == c_ST_SRAM_ACC) | (r_state == c_ST_UART_ACC) |
                       ((r_state == c_ST_IDLE) & w_slow_req);

    always_comb begin
        cpu_rdata = '0;
        if (r_state == c_ST_DONE) begin
            cpu_rdata = r_rdata;
        end else if (r_state == c_ST_IDLE && w_rd && w_region[c_RGN_UART_STA]) begin
            cpu_rdata = {30'b0, uart_mode};
        end
    end

    assign bus_error = r_bus_error;

endmodule : data_bus_bridge
`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_bridge
// Description : Directed self-checking bench for data_bus_bridge with a read
//               data scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_mask;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        sram_read_op;
    logic        sram_write_op;
    logic [31:0] sram_addr;
    logic [31:0] sram_data_write;
    logic [3:0]  sram_byte_mask;
    logic [31:0] sram_data_read;
    logic        uart_read_op;
    logic        uart_write_op;
    logic [31:0] uart_data_write;
    logic [31:0] uart_data_read;
    logic [1:0]  uart_mode;
    logic        vga_write_op;
    logic [31:0] vga_addr;
    logic [31:0] vga_data_write;
    logic        bus_error;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] rd_q[$];

    data_bus_bridge #(
        .SRAM_WAIT (2),
        .UART_WAIT (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_addr        (cpu_addr),
        .cpu_re          (cpu_re),
        .cpu_we          (cpu_we),
        .cpu_wdata       (cpu_wdata),
        .cpu_mask        (cpu_mask),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .sram_read_op    (sram_read_op),
        .sram_write_op   (sram_write_op),
        .sram_addr       (sram_addr),
        .sram_data_write (sram_data_write),
        .sram_byte_mask  (sram_byte_mask),
        .sram_data_read  (sram_data_read),
        .uart_read_op    (uart_read_op),
        .uart_write_op   (uart_write_op),
        .uart_data_write (uart_data_write),
        .uart_data_read  (uart_data_read),
        .uart_mode       (uart_mode),
        .vga_write_op    (vga_write_op),
        .vga_addr        (vga_addr),
        .vga_data_write  (vga_data_write),
        .bus_error       (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ops_vec();
        return {27'b0, vga_write_op, uart_write_op, uart_read_op, sram_write_op, sram_read_op};
    endfunction

    function automatic logic [31:0] pop_exp();
        if (rd_q.size() == 0) return 32'hBAD0_BAD0;
        return rd_q.pop_front();
    endfunction

    // Drive a stalling access (inputs held while stalled, scrambled mid-access)
    // and count stall / op cycles until the stall-free DONE cycle.
    task automatic run_slow(input string tag, input logic [31:0] addr, input logic re,
                            input logic we, input logic [31:0] wdata, input logic [3:0] mask,
                            input logic [31:0] exp_rd, input int exp_stall,
                            input bit is_sram, input logic [31:0] exp_addr);
        int n_stall = 0;
        int n_op    = 0;
        int n_other = 0;
        bit done    = 0;
        cpu_addr  = addr;
        cpu_re    = re;
        cpu_we    = we;
        cpu_wdata = wdata;
        cpu_mask  = mask;
        if (re && !we) rd_q.push_back(exp_rd);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cpu_stall) begin
                n_stall++;
                if (is_sram) begin
                    if (sram_read_op | sram_write_op) begin
                        n_op++;
                        check({tag, "_sram_addr"}, sram_addr, exp_addr);
                        check({tag, "_sram_dir"}, {31'b0, sram_write_op}, {31'b0, we});
                        if (we) check({tag, "_sram_wdata"}, sram_data_write, wdata);
                        if (we) check({tag, "_sram_mask"}, {28'b0, sram_byte_mask}, {28'b0, mask});
                    end
                    if (uart_read_op | uart_write_op | vga_write_op) n_other++;
                end else begin
                    if (uart_read_op | uart_write_op) begin
                        n_op++;
                        check({tag, "_uart_dir"}, {31'b0, uart_write_op}, {31'b0, we});
                        if (we) check({tag, "_uart_wdata"}, uart_data_write, wdata);
                    end
                    if (sram_read_op | sram_write_op | vga_write_op) n_other++;
                end
                if (n_stall == 2) begin
                    cpu_addr  = 32'h8041_2340;
                    cpu_wdata = ~wdata;
                    cpu_mask  = ~mask;
                end
            end else begin
                done = 1;
                check({tag, "_done_ops"}, ops_vec(), 32'h0);
                if (re && !we) check({tag, "_rdata"}, cpu_rdata, pop_exp());
            end
            @(posedge clk);
            #1;
        end
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        check({tag, "_completed"}, {31'b0, done}, 32'd1);
        check({tag, "_stall_cycles"}, n_stall, exp_stall);
        check({tag, "_op_cycles"}, n_op, exp_stall - 1);
        check({tag, "_other_ops"}, n_other, 0);
    endtask

    // Single-cycle no-stall access, observed mid-cycle.
    task automatic run_fast(input string tag, input logic [31:0] addr, input logic re,
                            input logic we, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input logic [31:0] exp_ops);
        cpu_addr  = addr;
        cpu_re    = re;
        cpu_we    = we;
        cpu_wdata = wdata;
        cpu_mask  = 4'hF;
        if (re && !we) rd_q.push_back(exp_rd);
        @(negedge clk);
        check({tag, "_stall"}, {31'b0, cpu_stall}, 32'd0);
        check({tag, "_ops"}, ops_vec(), exp_ops);
        if (re && !we) check({tag, "_rdata"}, cpu_rdata, pop_exp());
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        cpu_addr       = 32'h0;
        cpu_re         = 1'b0;
        cpu_we         = 1'b0;
        cpu_wdata      = 32'h0;
        cpu_mask       = 4'h0;
        sram_data_read = 32'hDEAD_BEEF;
        uart_data_read = 32'h0000_005A;
        uart_mode      = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ops", ops_vec(), 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_bus_error", {31'b0, bus_error}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle with status address but no request: no read data.
        cpu_addr = 32'hBFD0_03FC;
        @(negedge clk);
        check("idle_rdata", cpu_rdata, 32'h0);
        @(posedge clk);
        #1;

        run_slow("sram_rd", 32'h8040_0010, 1'b1, 1'b0, 32'h0, 4'hF,
                 32'hDEAD_BEEF, 3, 1'b1, 32'h0000_0010);
        run_slow("sram_wr", 32'h807F_FFFC, 1'b1, 1'b1, 32'h1234_5678, 4'b0101,
                 32'h0, 3, 1'b1, 32'h003F_FFFC);
        run_slow("uart_wr", 32'hBFD0_03F8, 1'b0, 1'b1, 32'h0000_0041, 4'hF,
                 32'h0, 2, 1'b0, 32'h0);
        run_slow("uart_rd", 32'hBFD0_03F8, 1'b1, 1'b0, 32'h0, 4'hF,
                 32'h0000_005A, 2, 1'b0, 32'h0);

        run_fast("stat_rd", 32'hBFD0_03FC, 1'b1, 1'b0, 32'h0, 32'h0000_0002, 32'h0);
        run_fast("stat_wr", 32'hBFD0_03FC, 1'b0, 1'b1, 32'hFF, 32'h0, 32'h0);

        cpu_addr  = 32'hBA00_0004;
        cpu_wdata = 32'h7;
        cpu_we    = 1'b1;
        @(negedge clk);
        check("vga_addr", vga_addr, 32'h0000_0004);
        check("vga_data", vga_data_write, 32'h7);
        run_fast("vga_wr", 32'hBA00_0004, 1'b0, 1'b1, 32'h7, 32'h0, 32'h10);
        @(negedge clk);
        check("vga_op_gone", ops_vec(), 32'h0);
        @(posedge clk);
        #1;
        run_fast("vga_rd", 32'hBA07_52FC, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        check("bus_error_clean", {31'b0, bus_error}, 32'd0);

        // Boundary just past the VGA window is unmapped.
        run_fast("vga_limit", 32'hBA07_5300, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        check("bus_error_vga_limit", {31'b0, bus_error}, 32'd1);

        // Reset clears the sticky flag; then a plain unmapped write sets it.
        rst = 1'b1;
        #2;
        check("bus_error_rst", {31'b0, bus_error}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_fast("unm_wr", 32'h0000_1000, 1'b0, 1'b1, 32'hCAFE, 32'h0, 32'h0);
        check("bus_error_set", {31'b0, bus_error}, 32'd1);
        run_fast("unm_rd", 32'h0000_1000, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        run_fast("sram_limit", 32'h8080_0000, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        run_slow("sram_rd2", 32'h8040_0000, 1'b1, 1'b0, 32'h0, 4'hF,
                 32'hDEAD_BEEF, 3, 1'b1, 32'h0);
        check("bus_error_sticky", {31'b0, bus_error}, 32'd1);

        // Reset in the second cycle of an SRAM write aborts it.
        cpu_addr  = 32'h8040_0100;
        cpu_we    = 1'b1;
        cpu_wdata = 32'h55;
        cpu_mask  = 4'hF;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_op_before", ops_vec(), 32'h2);
        #2;
        rst    = 1'b1;
        cpu_we = 1'b0;
        #1;
        check("abort_ops", ops_vec(), 32'h0);
        check("abort_stall", {31'b0, cpu_stall}, 32'd0);
        check("abort_bus_error", {31'b0, bus_error}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", ops_vec(), 32'h0);
        @(posedge clk);
        #1;
        sram_data_read = 32'h0BAD_F00D;
        run_slow("after_rst", 32'h8040_0020, 1'b1, 1'b0, 32'h0, 4'hF,
                 32'h0BAD_F00D, 3, 1'b1, 32'h0000_0020);
        check("queue_empty", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_data_bus_bridge
`default_nettype wire
